serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: width, default 5, operand and result bit width (width >= 2).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin a subtraction; sampled on rising clk.
REQ-005 A  input  width  minuend; sampled only on the accepting edge.
REQ-006 B  input  width  subtrahend; sampled only on the accepting edge.
REQ-007 Bin  input  1  borrow-in; sampled only on the accepting edge.
REQ-008 D  output  width  difference A - B - Bin, modulo 2^width.
REQ-009 Bout  output  1  borrow-out; 1 when A < B + Bin (unsigned).
REQ-010 busy  output  1  high while a subtraction is in progress.
REQ-011 done  output  1  one-cycle pulse marking D/Bout valid for the just-finished operation.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 IDLE or DONE with start=1 at an edge SHALL capture A, B and Bin into internal shift/borrow registers, clear the bit counter and go to SHIFT.
REQ-014 IDLE with start=0 SHALL stay in IDLE; DONE with start=0 SHALL go to IDLE.
REQ-015 SHIFT SHALL process one bit per edge, LSB first: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br).
REQ-016 SHIFT SHALL last exactly width edges, with the counter running 0..width-1, then go to DONE; it SHALL NOT wrap past width-1.
REQ-017 On the edge that leaves SHIFT, D SHALL load the full assembled difference and Bout the final borrow.
REQ-018 D and Bout SHALL change only on that edge or on reset; partial results SHALL NOT be visible on D.
REQ-019 Latency: with start accepted at edge k, done SHALL be high from edge k+width until edge k+width+1.
REQ-020 busy SHALL be 1 exactly in SHIFT, i.e. from edge k until edge k+width.
REQ-021 done SHALL be 1 exactly in DONE, and done and busy SHALL never both be 1.
REQ-022 start SHALL be ignored in SHIFT; A, B and Bin changing during SHIFT SHALL NOT affect the result.
REQ-023 start=1 in DONE SHALL be accepted (back-to-back operation); done still pulses for that cycle, and the new operation begins with no idle cycle.
REQ-024 Arithmetic SHALL be unsigned; {Bout, D} as a width+1-bit two's-complement value equals A - B - Bin.
REQ-025 Holding start high continuously SHALL produce one operation every width+1 cycles.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force: state IDLE, D=0, Bout=0, busy=0, done=0, counter and shift registers 0.
REQ-027 Reset asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow, and D/Bout SHALL stay 0.
REQ-028 After rst deasserts, the first start SHALL be accepted on the first rising edge that samples start=1.

Verification (width=5)
REQ-029 A=00001, B=00001, Bin=0, start pulse -> after 5 edges: done=1, D=00000, Bout=0; busy was high for exactly 5 cycles.
REQ-030 A=10001, B=01101, Bin=1 -> D=00011, Bout=0; A=10101, B=01010, Bin=0 -> D=01011, Bout=0.
REQ-031 A=00000, B=00001, Bin=1 -> D=11110, Bout=1; A=11111, B=11111, Bin=0 -> D=00000, Bout=0.
REQ-032 Start A=11111, B=00001; on the 2nd SHIFT cycle, pulse start with A=00000, B=11111 and change the A/B inputs -> the pulse is ignored; result D=11110, Bout=0.
REQ-033 Assert rst asynchronously (between edges) on the 3rd SHIFT cycle -> busy, D, Bout and done go to 0 at once; no done pulse follows; a new start after release completes normally.
REQ-034 start held high with A=00011, B=00001, Bin=0 -> done pulses every 6 cycles with D=00010 each time; busy is low only in the done cycles.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B - Bin computed LSB first, one bit per clock.
// D/Bout update only when the final bit is produced; busy marks SHIFT, done marks DONE.
module serial_subtractor #(
   parameter int width = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [width-1:0] A,
   input  logic [width-1:0] B,
   input  logic             Bin,
   output logic [width-1:0] D,
   output logic             Bout,
   output logic             busy,
   output logic             done
);

   localparam int CW = (width > 1) ? $clog2(width) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(width - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [width-1:0] a_q, a_d;
   logic [width-1:0] b_q, b_d;
   logic [width-1:0] acc_q, acc_d;
   logic [width-1:0] d_q, d_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             a_bit, b_bit, diff_bit, br_next, last;

   always_comb begin
      a_bit    = a_q[0];
      b_bit    = b_q[0];
      diff_bit = a_bit ^ b_bit ^ br_q;
      br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
      last     = (cnt_q == LAST_BIT);

      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      d_d     = d_q;
      br_d    = br_q;
      bout_d  = bout_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               br_d    = Bin;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            // Difference bits enter at the MSB so the word is aligned after width shifts.
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = br_next;
            acc_d = {diff_bit, acc_q[width-1:1]};
            if (last) begin
               d_d     = {diff_bit, acc_q[width-1:1]};
               bout_d  = br_next;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         d_q     <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         d_q     <= d_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign D    = d_q;
   assign Bout = bout_q;
   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (width=5) against an integer reference model.
module tb_serial_subtractor;

   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         Bin = 1'b0;
   logic [W-1:0] D;
   logic         Bout;
   logic         busy;
   logic         done;

   int tests = 0;
   int fails = 0;

   serial_subtractor #(.width(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .A    (A),
      .B    (B),
      .Bin  (Bin),
      .D    (D),
      .Bout (Bout),
      .busy (busy),
      .done (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer subtraction; borrow is the sign of the true result.
   function automatic logic [W:0] ref_sub(input int a, input int b, input int bin);
      int r;
      r = a - b - bin;
      return {(r < 0) ? 1'b1 : 1'b0, W'((r + 64) % 32)};
   endfunction

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input string tag);
      logic [W:0]   exp;
      logic [W-1:0] d_before;
      int           edges;
      int           busy_cnt;
      int           overlap;
      int           d_moved;
      exp = ref_sub(int'(a), int'(b), int'(bin));
      @(negedge clk);
      A = a; B = b; Bin = bin; start = 1'b1;
      d_before = D;
      @(posedge clk); #1;
      start = 1'b0;
      edges = 0; busy_cnt = 0; overlap = 0; d_moved = 0;
      while (!done && edges < 20) begin
         if (busy) busy_cnt++;
         if (D !== d_before || Bout === 1'bx) d_moved++;
         // Second SHIFT cycle gets a stray start with different operands; later ones are random.
         if (edges == 1) begin
            start = 1'b1; A = '0; B = '1; Bin = 1'b1;
         end else begin
            start = 1'($urandom); A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
         end
         @(posedge clk); #1;
         edges++;
         if (busy && done) overlap++;
      end
      start = 1'b0;
      chk({tag, "_latency"}, 32'(edges), 32'(W));
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
      chk({tag, "_no_overlap"}, 32'(overlap), 32'd0);
      chk({tag, "_D_stable"}, 32'(d_moved), 32'd0);
      chk({tag, "_D"}, 32'(D), 32'(exp[W-1:0]));
      chk({tag, "_Bout"}, 32'(Bout), 32'(exp[W]));
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, {30'd0, busy, done}, 32'd0);
   endtask

   initial begin
      logic [W:0] exp;
      int         done_cnt;
      int         bad_phase;
      int         bad_busy;
      int         bad_d;
      int         seen_done;

      #2;
      chk("reset_D", 32'(D), 32'd0);
      chk("reset_flags", {29'd0, Bout, busy, done}, 32'd0);
      @(negedge clk); rst = 1'b0;

      do_op(5'b00001, 5'b00001, 1'b0, "v029");
      do_op(5'b10001, 5'b01101, 1'b1, "v030a");
      do_op(5'b10101, 5'b01010, 1'b0, "v030b");
      do_op(5'b00000, 5'b00001, 1'b1, "v031a");
      do_op(5'b11111, 5'b11111, 1'b0, "v031b");
      do_op(5'b11111, 5'b00001, 1'b0, "v032");

      // Asynchronous reset part-way through SHIFT.
      @(negedge clk);
      A = 5'b10110; B = 5'b00011; Bin = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("arst_D", 32'(D), 32'd0);
      chk("arst_flags", {29'd0, Bout, busy, done}, 32'd0);
      @(negedge clk); rst = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done || busy || D !== '0 || Bout !== 1'b0) seen_done++;
      end
      chk("arst_no_done", 32'(seen_done), 32'd0);
      do_op(5'b01100, 5'b00101, 1'b1, "after_rst");

      // start held high: one result every W+1 cycles, busy low only while done.
      exp = ref_sub(3, 1, 0);
      @(negedge clk);
      A = 5'b00011; B = 5'b00001; Bin = 1'b0; start = 1'b1;
      done_cnt = 0; bad_phase = 0; bad_busy = 0; bad_d = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (busy === done) bad_busy++;
         if (done) begin
            done_cnt++;
            if (i % (W + 1) != W) bad_phase++;
            if (D !== exp[W-1:0] || Bout !== exp[W]) bad_d++;
         end
      end
      @(negedge clk); start = 1'b0;
      chk("hold_done_count", 32'(done_cnt), 32'd3);
      chk("hold_phase", 32'(bad_phase), 32'd0);
      chk("hold_busy", 32'(bad_busy), 32'd0);
      chk("hold_D", 32'(bad_d), 32'd0);
      repeat (W + 2) @(posedge clk);

      for (int n = 0; n < 25; n++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rnd%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
